// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the tile configuration loader.
// Chain indices select the bit/enable/token lanes in the top-level output registers.
package fpga_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LD_CLB,
      LD_CB,
      LD_SB,
      LD_SB2,
      CHK,
      DONE,
      ERR
   } state_e;

   localparam int unsigned CHAIN_CLB  = 0;
   localparam int unsigned CHAIN_CB   = 1;
   localparam int unsigned CHAIN_SB   = 2;
   localparam int unsigned CHAIN_SB2  = 3;
   localparam int unsigned NUM_CHAINS = 4;

   // Bit-counter width: enough to hold the longest chain length itself.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Byte stream carrying config data into the loader (valid/ready handshake).
interface fpga_cfg_loader_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/cfg_bit_serializer.sv
// 8-bit parallel-in serial-out shifter, MSB first; emits one bit per clock while loaded.
module cfg_bit_serializer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       empty,
   output logic       last
);

   logic [7:0] sh_q, sh_d;
   logic [3:0] cnt_q, cnt_d;

   // A load on the final shift cycle replaces the byte with no bubble.
   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      if (load) begin
         sh_d  = data;
         cnt_d = 4'd8;
      end else if (cnt_q != 4'd0) begin
         sh_d  = {sh_q[6:0], 1'b0};
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end

   assign bit_out   = sh_q[7];
   assign bit_valid = (cnt_q != 4'd0);
   assign empty     = (cnt_q == 4'd0);
   assign last      = (cnt_q == 4'd1);

endmodule

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: serialises config bytes into the CLB, CB, SB row-0 and SB row-1 chains,
// verifies a trailing XOR checksum and releases prgm_b on success.
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int unsigned CLB_BITS = 16,
   parameter int unsigned CB_BITS  = 32,
   parameter int unsigned SB_BITS  = 32,
   parameter int unsigned SB2_BITS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   fpga_cfg_loader_if.slave cfg,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             prgm_b,
   output logic             bit_in_CLB,
   output logic             bit_in_CB,
   output logic             bit_in_SB,
   output logic             bit_in_SB_2,
   output logic             CLB_prgm_b,
   output logic             cb_prgm_b,
   output logic             sb_prgm_b,
   output logic             sb_prgm_b_2,
   output logic             CLB_prgm_b_in,
   output logic             cb_prgm_b_in,
   output logic             sb_prgm_b_in
);

   localparam int unsigned CW = cnt_width(CLB_BITS, CB_BITS, SB_BITS, SB2_BITS);

   function automatic logic [CW-1:0] chain_bits(input state_e st);
      case (st)
         LD_CLB:  return CW'(CLB_BITS);
         LD_CB:   return CW'(CB_BITS);
         LD_SB:   return CW'(SB_BITS);
         LD_SB2:  return CW'(SB2_BITS);
         default: return '0;
      endcase
   endfunction

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [7:0]             csum_q, csum_d;
   logic [7:0]             chk_q, chk_d;
   logic                   chk_vld_q, chk_vld_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   prgm_b_q, prgm_b_d;
   logic [NUM_CHAINS-1:0]  bit_q, bit_d;
   logic [NUM_CHAINS-1:0]  en_n_q, en_n_d;
   logic [2:0]             tok_n_q, tok_n_d;

   logic in_ld, emit, chain_last, first_bit;
   logic s_ready, hs, is_chk_byte, ser_load;
   logic ser_bit, ser_valid, ser_empty, ser_last;
   logic [7:0] chk_val;

   cfg_bit_serializer u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .data      (cfg.s_data),
      .bit_out   (ser_bit),
      .bit_valid (ser_valid),
      .empty     (ser_empty),
      .last      (ser_last)
   );

   // A byte accepted on the final SB row-1 bit is the checksum; it is parked
   // in chk_q so CHK can compare it without a second handshake.
   always_comb begin
      in_ld       = (state_q == LD_CLB) || (state_q == LD_CB) ||
                    (state_q == LD_SB)  || (state_q == LD_SB2);
      emit        = in_ld && ser_valid;
      chain_last  = emit && (cnt_q == CW'(1));
      first_bit   = (cnt_q == chain_bits(state_q));
      s_ready     = (in_ld && (ser_empty || ser_last)) || ((state_q == CHK) && !chk_vld_q);
      hs          = cfg.s_valid && s_ready;
      is_chk_byte = hs && ((state_q == CHK) || ((state_q == LD_SB2) && chain_last));
      ser_load    = hs && !is_chk_byte;
      chk_val     = chk_vld_q ? chk_q : cfg.s_data;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      chk_d     = chk_q;
      chk_vld_d = chk_vld_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      prgm_b_d  = prgm_b_q;
      bit_d     = bit_q;
      en_n_d    = '1;
      tok_n_d   = '1;

      if (ser_load) csum_d = csum_q ^ cfg.s_data;

      if (emit) begin
         cnt_d = cnt_q - CW'(1);
         case (state_q)
            LD_CLB: begin
               bit_d[CHAIN_CLB]   = ser_bit;
               en_n_d[CHAIN_CLB]  = 1'b0;
               tok_n_d[CHAIN_CLB] = ~first_bit;
            end
            LD_CB: begin
               bit_d[CHAIN_CB]   = ser_bit;
               en_n_d[CHAIN_CB]  = 1'b0;
               tok_n_d[CHAIN_CB] = ~first_bit;
            end
            LD_SB: begin
               bit_d[CHAIN_SB]   = ser_bit;
               en_n_d[CHAIN_SB]  = 1'b0;
               tok_n_d[CHAIN_SB] = ~first_bit;
            end
            default: begin
               bit_d[CHAIN_SB2]  = ser_bit;
               en_n_d[CHAIN_SB2] = 1'b0;
            end
         endcase
      end

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d   = LD_CLB;
               cnt_d     = chain_bits(LD_CLB);
               csum_d    = '0;
               chk_vld_d = 1'b0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               err_d     = 1'b0;
               prgm_b_d  = 1'b0;
            end
         end
         LD_CLB: if (chain_last) begin
            state_d = LD_CB;
            cnt_d   = chain_bits(LD_CB);
         end
         LD_CB: if (chain_last) begin
            state_d = LD_SB;
            cnt_d   = chain_bits(LD_SB);
         end
         LD_SB: if (chain_last) begin
            state_d = LD_SB2;
            cnt_d   = chain_bits(LD_SB2);
         end
         LD_SB2: if (chain_last) begin
            state_d = CHK;
            cnt_d   = '0;
            if (is_chk_byte) begin
               chk_d     = cfg.s_data;
               chk_vld_d = 1'b1;
            end
         end
         CHK: begin
            if (chk_vld_q || hs) begin
               chk_vld_d = 1'b0;
               busy_d    = 1'b0;
               if (chk_val == csum_q) begin
                  state_d  = DONE;
                  done_d   = 1'b1;
                  prgm_b_d = 1'b1;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         csum_q    <= '0;
         chk_q     <= '0;
         chk_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         prgm_b_q  <= 1'b1;
         bit_q     <= '0;
         en_n_q    <= '1;
         tok_n_q   <= '1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         csum_q    <= csum_d;
         chk_q     <= chk_d;
         chk_vld_q <= chk_vld_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         prgm_b_q  <= prgm_b_d;
         bit_q     <= bit_d;
         en_n_q    <= en_n_d;
         tok_n_q   <= tok_n_d;
      end
   end

   assign cfg.s_ready    = s_ready;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
   assign prgm_b         = prgm_b_q;
   assign bit_in_CLB     = bit_q[CHAIN_CLB];
   assign bit_in_CB      = bit_q[CHAIN_CB];
   assign bit_in_SB      = bit_q[CHAIN_SB];
   assign bit_in_SB_2    = bit_q[CHAIN_SB2];
   assign CLB_prgm_b     = en_n_q[CHAIN_CLB];
   assign cb_prgm_b      = en_n_q[CHAIN_CB];
   assign sb_prgm_b      = en_n_q[CHAIN_SB];
   assign sb_prgm_b_2    = en_n_q[CHAIN_SB2];
   assign CLB_prgm_b_in  = tok_n_q[CHAIN_CLB];
   assign cb_prgm_b_in   = tok_n_q[CHAIN_CB];
   assign sb_prgm_b_in   = tok_n_q[CHAIN_SB];

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader with CLB=16, CB=8, SB=8, SB2=8 chain lengths.
module tb_fpga_cfg_loader;

   typedef struct packed {
      logic [1:0] ch;
      logic       b;
      logic [2:0] tok;   // {sb, cb, clb} head tokens, active low
   } exp_t;

   typedef struct packed {
      logic done;
      logic err;
      logic prgm_b;
   } res_t;

   // Bytes 0-1 fill CLB, 2 CB, 3 SB, 4 SB2.  XOR of all five = 0xE7.
   localparam logic [7:0] CFG [5] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81};

   logic clk = 1'b0;
   logic reset, start;
   logic busy, done, err, prgm_b;
   logic bit_in_CLB, bit_in_CB, bit_in_SB, bit_in_SB_2;
   logic CLB_prgm_b, cb_prgm_b, sb_prgm_b, sb_prgm_b_2;
   logic CLB_prgm_b_in, cb_prgm_b_in, sb_prgm_b_in;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   bit   mon_en = 1'b0;
   bit   fin_prev = 1'b0;
   exp_t sb_q[$];
   res_t res_q[$];

   fpga_cfg_loader_if cfg_if ();

   fpga_cfg_loader #(
      .CLB_BITS (16),
      .CB_BITS  (8),
      .SB_BITS  (8),
      .SB2_BITS (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .cfg           (cfg_if),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .prgm_b        (prgm_b),
      .bit_in_CLB    (bit_in_CLB),
      .bit_in_CB     (bit_in_CB),
      .bit_in_SB     (bit_in_SB),
      .bit_in_SB_2   (bit_in_SB_2),
      .CLB_prgm_b    (CLB_prgm_b),
      .cb_prgm_b     (cb_prgm_b),
      .sb_prgm_b     (sb_prgm_b),
      .sb_prgm_b_2   (sb_prgm_b_2),
      .CLB_prgm_b_in (CLB_prgm_b_in),
      .cb_prgm_b_in  (cb_prgm_b_in),
      .sb_prgm_b_in  (sb_prgm_b_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Monitor: pops one expected bit per asserted shift enable, one result per done/err rise.
   always @(negedge clk) begin
      logic [3:0] low, bits, exp_low;
      logic [2:0] tok;
      exp_t       e;
      res_t       r;
      bit         fin;
      if (mon_en) begin
         low  = ~{sb_prgm_b_2, sb_prgm_b, cb_prgm_b, CLB_prgm_b};
         bits = {bit_in_SB_2, bit_in_SB, bit_in_CB, bit_in_CLB};
         tok  = {sb_prgm_b_in, cb_prgm_b_in, CLB_prgm_b_in};
         if (sb_q.size() == 0) begin
            if (busy || low != 4'd0) begin
               checks++;
               if ({low, tok} !== {4'd0, 3'b111}) begin
                  errors++;
                  $display("FAIL idle_enable en_low=%b tok=%b required en_low=0000 tok=111", low, tok);
               end
            end
         end else if (low != 4'd0) begin
            e       = sb_q.pop_front();
            exp_low = 4'b0001 << e.ch;
            checks++;
            if ({low, bits[e.ch], tok} !== {exp_low, e.b, e.tok}) begin
               errors++;
               $display("FAIL chain_bit en_low=%b bit=%b tok=%b required en_low=%b bit=%b tok=%b",
                        low, bits[e.ch], tok, exp_low, e.b, e.tok);
            end
            if (e.ch == 2'd0 && e.tok == 3'b110) begin
               checks++;
               if (cyc - start_cyc != 2) begin
                  errors++;
                  $display("FAIL first_bit_latency got=%0d required=2", cyc - start_cyc);
               end
            end
         end else begin
            checks++;
            if (tok !== 3'b111) begin
               errors++;
               $display("FAIL stray_token tok=%b required=111", tok);
            end
         end

         fin = done | err;
         if (fin && !fin_prev) begin
            checks++;
            if (res_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result done=%b err=%b", done, err);
            end else begin
               r = res_q.pop_front();
               if ({done, err, prgm_b, busy} !== {r.done, r.err, r.prgm_b, 1'b0}) begin
                  errors++;
                  $display("FAIL result done/err/prgm_b/busy=%b%b%b%b required=%b%b%b0",
                           done, err, prgm_b, busy, r.done, r.err, r.prgm_b);
               end
            end
         end
         fin_prev = fin;
      end
   end

   task automatic check_reset_vals(input string name);
      logic [15:0] act;
      act = {bit_in_SB_2, bit_in_SB, bit_in_CB, bit_in_CLB,
             sb_prgm_b_2, sb_prgm_b, cb_prgm_b, CLB_prgm_b,
             sb_prgm_b_in, cb_prgm_b_in, CLB_prgm_b_in,
             busy, done, err, prgm_b, cfg_if.s_ready};
      checks++;
      if (act !== 16'b0000_1111_111_0001_0) begin
         errors++;
         $display("FAIL %s outputs=%b required=%b", name, act, 16'b0000_1111_111_0001_0);
      end
   endtask

   task automatic push_bits(input int idx, input logic [7:0] b);
      exp_t       e;
      logic [1:0] ch;
      case (idx)
         0, 1:    ch = 2'd0;
         2:       ch = 2'd1;
         3:       ch = 2'd2;
         default: ch = 2'd3;
      endcase
      for (int k = 0; k < 8; k++) begin
         e.ch  = ch;
         e.b   = b[7-k];
         e.tok = 3'b111;
         if (k == 0) begin
            case (idx)
               0:       e.tok = 3'b110;
               2:       e.tok = 3'b101;
               3:       e.tok = 3'b011;
               default: e.tok = 3'b111;
            endcase
         end
         sb_q.push_back(e);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit st, output bit ok);
      ok             = 1'b0;
      cfg_if.s_data  = b;
      cfg_if.s_valid = 1'b1;
      start          = st;
      for (int n = 0; n < 64 && !ok; n++) begin
         #1;
         if (cfg_if.s_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL handshake_timeout byte=%h accepted=0 required=1", b);
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      start_cyc = cyc;
      checks++;
      if ({busy, done, err, prgm_b} !== 4'b1000) begin
         errors++;
         $display("FAIL start_state busy/done/err/prgm_b=%b%b%b%b required=1000", busy, done, err, prgm_b);
      end
   endtask

   task automatic wait_fin();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = done | err;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL completion_timeout done|err=0 required=1");
      end
   endtask

   task automatic run_stream(input logic [7:0] chk, input int gap_after, input int busy_start_at);
      logic [7:0] sum;
      res_t       r;
      bit         ok;
      sum = '0;
      for (int i = 0; i < 5; i++) begin
         sum ^= CFG[i];
         push_bits(i, CFG[i]);
         send_byte(CFG[i], (i == busy_start_at), ok);
         if (i == gap_after) begin
            // let the shifter run dry for ~5 clks with nothing offered
            cfg_if.s_valid = 1'b0;
            repeat (13) @(negedge clk);
         end
      end
      r.done   = (chk == sum);
      r.err    = (chk != sum);
      r.prgm_b = (chk == sum);
      res_q.push_back(r);
      send_byte(chk, 1'b0, ok);
      cfg_if.s_valid = 1'b0;
      wait_fin();
   endtask

   initial begin
      bit ok;
      reset          = 1'b0;
      start          = 1'b0;
      cfg_if.s_data  = 8'h00;
      cfg_if.s_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset_state");
      mon_en = 1'b1;
      reset  = 1'b1;

      // Nominal load, correct checksum
      do_start();
      run_stream(8'hE7, -1, -1);

      // Bytes offered in DONE are not taken
      cfg_if.s_data  = 8'h55;
      cfg_if.s_valid = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({cfg_if.s_ready, done, busy} !== 3'b010) begin
         errors++;
         $display("FAIL done_no_consume ready/done/busy=%b%b%b required=010", cfg_if.s_ready, done, busy);
      end
      cfg_if.s_valid = 1'b0;

      // Restart from DONE, with an ignored start pulse mid-load
      do_start();
      run_stream(8'hE7, -1, 2);

      // Bad checksum
      do_start();
      run_stream(8'h00, -1, -1);

      // Back-pressure between bytes 2 and 3, restarted from ERR
      do_start();
      run_stream(8'hE7, 1, -1);

      // Reset while the 3rd CB bit is on the chain
      do_start();
      for (int i = 0; i < 3; i++) begin
         push_bits(i, CFG[i]);
         send_byte(CFG[i], 1'b0, ok);
      end
      cfg_if.s_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      sb_q.delete();
      @(negedge clk);
      check_reset_vals("reset_midload");
      reset = 1'b1;
      do_start();
      run_stream(8'hE7, -1, -1);

      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0 || res_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain bits_left=%0d results_left=%0d required=0", sb_q.size(), res_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
